// File: rtl/axis_sig_sink.sv
// Stream sink for the multiplier result: accepts z beats, folds them into a 64-bit MISR,
// checks tlast framing and counts packets, then freezes the signature once NPKT packets arrive.
module axis_sig_sink #(
  parameter int unsigned N          = 16,
  parameter int unsigned QW         = 64,
  parameter int unsigned NPKT       = 256,
  parameter logic [63:0] POLY       = 64'h800000000000000D,
  parameter int unsigned BP_MODE    = 0,
  parameter logic [15:0] BP_SEED    = 16'hACE1,
  localparam int unsigned PktW      = $clog2(NPKT + 1),
  localparam int unsigned BeatW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic            start,
  input  logic [QW-1:0]   z_tdata,
  input  logic            z_tvalid,
  output logic            z_tready,
  input  logic            z_tlast,
  output logic [63:0]     signature,
  output logic [PktW-1:0] pkt_cnt,
  output logic            frame_err,
  output logic            done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [63:0]      sig_q, sig_d;
  logic [PktW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             tready_q, tready_d;
  logic [63:0]      d64;
  logic             accept;
  logic             lfsr_fb;

  if (QW >= 64) begin : g_trunc
    assign d64 = z_tdata[63:0];
  end else begin : g_ext
    assign d64 = {{(64 - QW){1'b0}}, z_tdata};
  end

  assign accept  = z_tvalid & tready_q;
  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    pkt_cnt_d   = pkt_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    frame_err_d = frame_err_q;
    lfsr_d      = lfsr_q;

    if ((BP_MODE != 0) && (state_q == StRun)) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          sig_d       = '0;
          pkt_cnt_d   = '0;
          beat_cnt_d  = '0;
          frame_err_d = 1'b0;
        end
      end
      StRun: begin
        if (accept) begin
          sig_d = {sig_q[62:0], 1'b0} ^ (sig_q[63] ? POLY : 64'h0) ^ d64;
          if (z_tlast) begin
            if (beat_cnt_q != BeatW'(N - 1)) begin
              frame_err_d = 1'b1;
            end
            beat_cnt_d = '0;
            pkt_cnt_d  = pkt_cnt_q + PktW'(1);
            if (pkt_cnt_q == PktW'(NPKT - 1)) begin
              state_d = StDone;
            end
          end else if (beat_cnt_q == BeatW'(N - 1)) begin
            // Overlong packet: flag it but do not count a packet without tlast
            frame_err_d = 1'b1;
            beat_cnt_d  = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BeatW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tready is registered from the next state so it drops with the final beat
    tready_d = (state_d == StRun) && ((BP_MODE == 0) || lfsr_d[0]);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= StIdle;
      sig_q       <= '0;
      pkt_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      lfsr_q      <= BP_SEED;
      tready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      pkt_cnt_q   <= pkt_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_err_q <= frame_err_d;
      lfsr_q      <= lfsr_d;
      tready_q    <= tready_d;
    end
  end

  assign z_tready  = tready_q;
  assign signature = sig_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign frame_err = frame_err_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_axis_sig_sink.sv
// Bench for axis_sig_sink: two instances (no backpressure, LFSR backpressure) checked every
// cycle against a behavioural model, plus hand-computed signature/count expectations.
module tb_axis_sig_sink;

  localparam logic [63:0] Poly = 64'h800000000000000D;
  localparam int unsigned NB = 4;

  logic        clk = 1'b0;
  logic        arstn;
  logic        start_a  [2];
  logic [63:0] tdata_a  [2];
  logic        tvalid_a [2];
  logic        tlast_a  [2];

  logic        tready0, tready1, err0, err1, done0, done1;
  logic [63:0] sig0, sig1;
  logic [1:0]  pkt0;
  logic [3:0]  pkt1;

  logic [1:0]  tready_v, err_v, done_v;
  logic [63:0] sig_v [2];
  logic [3:0]  pkt_v [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_sig_sink #(.N(NB), .QW(64), .NPKT(2), .POLY(Poly), .BP_MODE(0), .BP_SEED(16'hACE1)) u_dut0 (
    .clk(clk), .arstn(arstn), .start(start_a[0]), .z_tdata(tdata_a[0]), .z_tvalid(tvalid_a[0]),
    .z_tready(tready0), .z_tlast(tlast_a[0]), .signature(sig0), .pkt_cnt(pkt0),
    .frame_err(err0), .done(done0)
  );

  axis_sig_sink #(.N(NB), .QW(64), .NPKT(8), .POLY(Poly), .BP_MODE(1), .BP_SEED(16'hACE1)) u_dut1 (
    .clk(clk), .arstn(arstn), .start(start_a[1]), .z_tdata(tdata_a[1]), .z_tvalid(tvalid_a[1]),
    .z_tready(tready1), .z_tlast(tlast_a[1]), .signature(sig1), .pkt_cnt(pkt1),
    .frame_err(err1), .done(done1)
  );

  always_comb begin
    tready_v = {tready1, tready0};
    err_v    = {err1, err0};
    done_v   = {done1, done0};
    sig_v[0] = sig0;
    sig_v[1] = sig1;
    pkt_v[0] = {2'b00, pkt0};
    pkt_v[1] = pkt1;
  end

  function automatic logic [63:0] misr(input logic [63:0] s, input logic [63:0] d);
    return {s[62:0], 1'b0} ^ (s[63] ? Poly : 64'h0) ^ d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: run/done flags, signature, beat index within packet, packet count
  bit          m_run  [2];
  bit          m_done [2];
  bit          m_err  [2];
  logic [63:0] m_sig  [2];
  int          m_pkt  [2];
  int          m_beat [2];
  logic [15:0] m_lfsr [2];

  function automatic bit exp_ready(input int g);
    return m_run[g] && ((g == 0) || m_lfsr[g][0]);
  endfunction

  always @(posedge clk or negedge arstn) begin
    for (int g = 0; g < 2; g++) begin
      if (!arstn) begin
        m_run[g] = 0; m_done[g] = 0; m_err[g] = 0; m_sig[g] = '0;
        m_pkt[g] = 0; m_beat[g] = 0; m_lfsr[g] = 16'hACE1;
      end else begin
        automatic bit acc = exp_ready(g) && tvalid_a[g];
        automatic int npkt = (g == 0) ? 2 : 8;
        if (m_run[g] && g == 1) begin
          m_lfsr[g] = {m_lfsr[g][0] ^ m_lfsr[g][2] ^ m_lfsr[g][3] ^ m_lfsr[g][5],
                       m_lfsr[g][15:1]};
        end
        if (start_a[g] && !m_run[g]) begin
          m_run[g] = 1; m_done[g] = 0; m_err[g] = 0; m_sig[g] = '0;
          m_pkt[g] = 0; m_beat[g] = 0;
        end else if (acc) begin
          m_sig[g] = misr(m_sig[g], tdata_a[g]);
          if (tlast_a[g]) begin
            if (m_beat[g] != NB - 1) m_err[g] = 1;
            m_beat[g] = 0;
            m_pkt[g]++;
            if (m_pkt[g] == npkt) begin
              m_run[g] = 0; m_done[g] = 1;
            end
          end else begin
            m_beat[g]++;
            if (m_beat[g] == NB) begin
              m_beat[g] = 0; m_err[g] = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      check($sformatf("dut%0d signature", g), sig_v[g], m_sig[g]);
      check($sformatf("dut%0d pkt_cnt", g), 64'(pkt_v[g]), 64'(m_pkt[g]));
      check($sformatf("dut%0d frame_err", g), 64'(err_v[g]), 64'(m_err[g]));
      check($sformatf("dut%0d done", g), 64'(done_v[g]), 64'(m_done[g]));
      check($sformatf("dut%0d tready", g), 64'(tready_v[g]), 64'(exp_ready(g)));
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted, tvalid left high
  task automatic send(input int g, input logic [63:0] d, input logic l);
    int n = 0;
    logic acc;
    tdata_a[g] = d; tlast_a[g] = l; tvalid_a[g] = 1'b1;
    do begin
      acc = tready_v[g];
      @(negedge clk);
      n++;
    end while (!acc && n < 200);
    check($sformatf("dut%0d beat accepted", g), 64'(acc), 64'd1);
  endtask

  task automatic idle(input int g);
    tvalid_a[g] = 1'b0; tlast_a[g] = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    start_a[g] = 1'b1;
    @(negedge clk);
    start_a[g] = 1'b0;
  endtask

  task automatic send_pkt(input int g);
    for (int i = 1; i <= 4; i++) send(g, 64'(i), i == 4);
    idle(g);
  endtask

  task automatic toggle_valid(input int g, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tvalid_a[g] = 1'($urandom_range(0, 1));
      tlast_a[g]  = 1'($urandom_range(0, 1));
      tdata_a[g]  = {$urandom, $urandom};
      @(negedge clk);
    end
    idle(g);
  endtask

  logic [63:0] t3_data [32];
  logic [63:0] t3_sig;

  initial begin
    arstn = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start_a[g] = 0; tdata_a[g] = '0; tvalid_a[g] = 0; tlast_a[g] = 0;
    end
    repeat (2) @(negedge clk);
    check("reset signature", sig0, 64'h0);
    check("reset tready", 64'(tready0), 64'd0);
    check("reset done", 64'(done0), 64'd0);
    arstn = 1'b1;
    @(negedge clk);

    // T1: two clean packets 1,2,3,4
    pulse_start(0);
    send_pkt(0);
    check("t1 sig after pkt1", sig0, 64'h2);
    check("t1 pkt_cnt after pkt1", 64'(pkt0), 64'd1);
    send_pkt(0);
    check("t1 sig after pkt2", sig0, 64'h22);
    check("t1 done", 64'(done0), 64'd1);
    check("t1 tready in done", 64'(tready0), 64'd0);
    check("t1 frame_err", 64'(err0), 64'd0);

    // T6: tvalid noise in DONE
    toggle_valid(0, 10);
    check("t6 sig held in done", sig0, 64'h22);
    check("t6 pkt held in done", 64'(pkt0), 64'd2);

    // T5: restart from DONE, start ignored mid-packet, identical rerun
    pulse_start(0);
    check("t5 sig cleared", sig0, 64'h0);
    check("t5 pkt cleared", 64'(pkt0), 64'd0);
    send(0, 64'd1, 1'b0);
    send(0, 64'd2, 1'b0);
    idle(0);
    pulse_start(0);
    send(0, 64'd3, 1'b0);
    send(0, 64'd4, 1'b1);
    idle(0);
    send_pkt(0);
    check("t5 rerun sig", sig0, 64'h22);

    // T2: short packet, then overlong run without tlast, then a clean packet
    pulse_start(0);
    for (int i = 1; i <= 3; i++) send(0, 64'(i), i == 3);
    idle(0);
    check("t2 short sig", sig0, 64'h3);
    check("t2 short err", 64'(err0), 64'd1);
    check("t2 short pkt", 64'(pkt0), 64'd1);
    for (int i = 5; i <= 8; i++) send(0, 64'(i), 1'b0);
    idle(0);
    check("t2 long pkt", 64'(pkt0), 64'd1);
    send_pkt(0);
    check("t2 err sticky", 64'(err0), 64'd1);
    check("t2 done", 64'(done0), 64'd1);

    // T4: asynchronous reset mid-packet, then IDLE noise and a fresh packet
    pulse_start(0);
    send(0, 64'd1, 1'b0);
    send(0, 64'd2, 1'b0);
    tdata_a[0] = 64'd3;
    #2 arstn = 1'b0;
    #1;
    check("t4 async sig", sig0, 64'h0);
    check("t4 async tready", 64'(tready0), 64'd0);
    check("t4 async pkt", 64'(pkt0), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    toggle_valid(0, 8);
    check("t6 sig held in idle", sig0, 64'h0);
    pulse_start(0);
    send_pkt(0);
    check("t4 fresh sig", sig0, 64'h2);

    // T3: backpressured instance, tvalid held high across 8 packets
    for (int i = 0; i < 32; i++) t3_data[i] = {$urandom, $urandom};
    t3_sig = '0;
    for (int i = 0; i < 32; i++) t3_sig = misr(t3_sig, t3_data[i]);
    pulse_start(1);
    for (int i = 0; i < 32; i++) send(1, t3_data[i], (i % 4) == 3);
    idle(1);
    check("t3 sig vs unthrottled fold", sig1, t3_sig);
    check("t3 pkt_cnt", 64'(pkt1), 64'd8);
    check("t3 done", 64'(done1), 64'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
